dct_mac_unit: RTL

Pipelined multiply-accumulate datapath for the 8x8 MPEG forward DCT, directly downstream of the DCT control FSM. It consumes the FSM's per-term strobe, its (u,v,x,y) indices and the pixel read from block memory. It accumulates the 64 products pixel·T[u][x]·T[v][y] for each coefficient, then emits one rounded 12-bit coefficient with its (u,v) address. It also checks that the term sequence is well-formed.

---
 rtl/dct_mac_unit.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/dct_mac_unit.sv
`timescale 1ns/1ps
// Purpose : 8x8 forward-DCT multiply-accumulate; sums pixel*T[u][x]*T[v][y] over a block, emits a rounded coefficient.
// Latency : 5 clock edges from the act_mac carrying the last term (x=7,y=7) to the coef_valid pulse.
// Backpr. : none; one term accepted every cycle, bubbles allowed, clr flushes the pipeline.
//
// Ports   : clk, rst_in (async, active-high), clr (sync flush), act_mac + u/v/x/y/pixel (term input),
//           coef/coef_valid/coef_addr ({v,u}) result, seq_err (sticky term-order error).
// Config  : DCT_MAC_LEVEL_SHIFT_EN defined -> pixel operand is pixel-128; undefined -> pixel zero-extended.
module dct_mac_unit (
    input  logic               clk,
    input  logic               rst_in,
    input  logic               clr,
    input  logic               act_mac,
    input  logic [2:0]         u,
    input  logic [2:0]         v,
    input  logic [2:0]         x,
    input  logic [2:0]         y,
    input  logic [7:0]         pixel,
    output logic signed [11:0] coef,
    output logic               coef_valid,
    output logic [5:0]         coef_addr,
    output logic               seq_err
);

    // Per-term tag carried alongside the datapath.
    typedef struct packed {
        logic       first;
        logic       last;
        logic [5:0] addr;
    } tag_t;

    // Cosine basis T[k][n] = round(64*cos((2n+1)k*pi/16)) for k>0, 45 for k=0.
    // The angle index is folded into the first quadrant so only nine magnitudes are stored.
    function automatic logic signed [7:0] trom(input logic [2:0] k, input logic [2:0] n);
        logic [6:0] prod;
        logic [4:0] m;
        logic [4:0] idx;
        logic       neg;
        logic [7:0] mag;
        prod = {3'b000, n, 1'b1} * {4'b0000, k};
        m    = prod[4:0];
        if (m <= 5'd8) begin
            idx = m;
            neg = 1'b0;
        end else if (m <= 5'd16) begin
            idx = 5'd16 - m;
            neg = 1'b1;
        end else if (m <= 5'd24) begin
            idx = m - 5'd16;
            neg = 1'b1;
        end else begin
            idx = 5'd0 - m;   // 32 - m modulo 32
            neg = 1'b0;
        end
        case (idx)
            5'd0:    mag = 8'd64;
            5'd1:    mag = 8'd63;
            5'd2:    mag = 8'd59;
            5'd3:    mag = 8'd53;
            5'd4:    mag = 8'd45;
            5'd5:    mag = 8'd36;
            5'd6:    mag = 8'd24;
            5'd7:    mag = 8'd12;
            default: mag = 8'd0;
        endcase
        if (k == 3'd0) begin
            mag = 8'd45;
            neg = 1'b0;
        end
        return $signed(neg ? (8'd0 - mag) : mag);
    endfunction

    logic signed [8:0]  p_nxt;
    logic signed [7:0]  cu_nxt;
    logic signed [7:0]  cv_nxt;
    tag_t               tag_nxt;

    always_comb begin
`ifdef DCT_MAC_LEVEL_SHIFT_EN
        p_nxt = {1'b0, pixel} - 9'd128;
`else
        p_nxt = {1'b0, pixel};
`endif
        cu_nxt        = trom(u, x);
        cv_nxt        = trom(v, y);
        tag_nxt.first = (x == 3'd0) && (y == 3'd0);
        tag_nxt.last  = (x == 3'd7) && (y == 3'd7);
        tag_nxt.addr  = {v, u};
    end

    // Pipeline stages
    logic               s1_vld, s2_vld, s3_vld, s4_vld;
    logic signed [8:0]  s1_p, s2_p;
    logic signed [7:0]  s1_cu, s1_cv;
    logic signed [15:0] s2_w;
    logic signed [24:0] s3_m;
    logic signed [31:0] acc;
    tag_t               s1_tag, s2_tag, s3_tag, s4_tag;

    // Sequence checker state
    logic [5:0]         exp_idx;
    logic [5:0]         blk_uv;

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            s1_vld     <= 1'b0;
            s2_vld     <= 1'b0;
            s3_vld     <= 1'b0;
            s4_vld     <= 1'b0;
            s1_p       <= '0;
            s2_p       <= '0;
            s1_cu      <= '0;
            s1_cv      <= '0;
            s2_w       <= '0;
            s3_m       <= '0;
            acc        <= '0;
            s1_tag     <= '0;
            s2_tag     <= '0;
            s3_tag     <= '0;
            s4_tag     <= '0;
            coef       <= '0;
            coef_valid <= 1'b0;
            coef_addr  <= '0;
        end else if (clr) begin
            // Flush: the term presented alongside clr is dropped, and a pending output load is suppressed.
            s1_vld     <= 1'b0;
            s2_vld     <= 1'b0;
            s3_vld     <= 1'b0;
            s4_vld     <= 1'b0;
            acc        <= '0;
            coef_valid <= 1'b0;
        end else begin
            s1_vld <= act_mac;
            if (act_mac) begin
                s1_p   <= p_nxt;
                s1_cu  <= cu_nxt;
                s1_cv  <= cv_nxt;
                s1_tag <= tag_nxt;
            end

            s2_vld <= s1_vld;
            s2_w   <= 16'(s1_cu) * 16'(s1_cv);
            s2_p   <= s1_p;
            s2_tag <= s1_tag;

            s3_vld <= s2_vld;
            s3_m   <= 25'(s2_w) * 25'(s2_p);
            s3_tag <= s2_tag;

            // The first term loads instead of adding, so a new block can follow the previous last term directly.
            s4_vld <= s3_vld;
            if (s3_vld) begin
                acc    <= s3_tag.first ? 32'(s3_m) : acc + 32'(s3_m);
                s4_tag <= s3_tag;
            end

            // acc here already includes the last term; round half up then take bits [25:14].
            coef_valid <= s4_vld && s4_tag.last;
            if (s4_vld && s4_tag.last) begin
                coef      <= 12'((acc + 32'sd8192) >>> 14);
                coef_addr <= s4_tag.addr;
            end
        end
    end

    // Term-order checker: {x,y} must count 0..63 and (u,v) must stay fixed within a block.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            exp_idx <= '0;
            blk_uv  <= '0;
            seq_err <= 1'b0;
        end else if (clr) begin
            exp_idx <= '0;
            seq_err <= 1'b0;
        end else if (act_mac) begin
            if (({x, y} != exp_idx) || ((exp_idx != 6'd0) && ({v, u} != blk_uv))) begin
                seq_err <= 1'b1;
            end
            if (exp_idx == 6'd0) begin
                blk_uv <= {v, u};
            end
            // Resynchronise on the observed index; after the last term this wraps to 0.
            exp_idx <= {x, y} + 6'd1;
        end
    end

endmodule
